// File: rtl/gamepad_serial_reader_if.sv
// Pad-side bus shared by two NES-style serial gamepads: a common latch and shift
// clock going out to both pads, and one serial data line coming back from each.
interface gamepad_serial_reader_if;
   logic pad_latch;
   logic pad_clk;
   logic pad_data1;
   logic pad_data2;

   modport master (
      output pad_latch,
      output pad_clk,
      input  pad_data1,
      input  pad_data2
   );

   modport slave (
      input  pad_latch,
      input  pad_clk,
      output pad_data1,
      output pad_data2
   );
endinterface

// File: rtl/gamepad_serial_reader.sv
// Polls two NES serial gamepads once per vsync rising edge and commits active-high,
// console-ordered button words together with a per-pad validity flag.
module gamepad_serial_reader #(
   parameter int CLK_DIV = 24
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   vsync,
   gamepad_serial_reader_if.master pad,
   output logic [7:0]             switches_p1,
   output logic [7:0]             switches_p2,
   output logic [1:0]             present,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_BIT_LO,
      S_BIT_HI,
      S_COMMIT
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t      r_state;
   state_t      w_next;
   logic        r_vsync_q;
   logic [7:0]  r_div;
   logic        r_half;
   logic [2:0]  r_bit;
   logic [7:0]  r_sh1;
   logic [7:0]  r_sh2;
   logic [7:0]  r_sw1;
   logic [7:0]  r_sw2;
   logic [1:0]  r_present;

   logic        w_start;
   logic        w_last;
   logic        w_entering;
   logic        w_sample;
   logic        w_commit;
   logic        w_latch;
   logic        w_pclk;
   logic        w_busy;
   logic        w_done;

   // Shift order is A,B,Select,Start,Up,Down,Left,Right; console order is L,R,U,D,A,B,Sel,Start.
   function automatic logic [7:0] map_pad(input logic [7:0] s);
      return {s[3], s[2], s[1], s[0], s[5], s[4], s[7], s[6]};
   endfunction

   // Inverted samples all high means the raw line never left 0: shorted or pulled low.
   function automatic logic pad_valid(input logic [7:0] s);
      return s != 8'hFF;
   endfunction

   assign w_start    = vsync & ~r_vsync_q;
   assign w_last     = (r_div == DIV_LAST);
   assign w_entering = (w_next != r_state);
   assign w_sample   = (r_state == S_BIT_LO) && w_last;
   assign w_commit   = (r_state == S_BIT_HI) && w_last && (r_bit == 3'd7);

   always_comb begin
      w_next  = r_state;
      w_latch = 1'b0;
      w_pclk  = 1'b0;
      w_busy  = 1'b1;
      w_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (w_start) begin
               w_next = S_LATCH;
            end
         end
         S_LATCH: begin
            w_latch = 1'b1;
            if (w_last && r_half) begin
               w_next = S_BIT_LO;
            end
         end
         S_BIT_LO: begin
            if (w_last) begin
               w_next = S_BIT_HI;
            end
         end
         S_BIT_HI: begin
            w_pclk = 1'b1;
            if (w_last) begin
               w_next = (r_bit == 3'd7) ? S_COMMIT : S_BIT_LO;
            end
         end
         S_COMMIT: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_vsync_q <= 1'b1;
      end else begin
         r_state   <= w_next;
         r_vsync_q <= vsync;
      end
   end

   // The latch phase spans two divider periods; r_half marks the second one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div  <= 8'd0;
         r_half <= 1'b0;
         r_bit  <= 3'd0;
      end else begin
         if (w_entering || r_state == S_IDLE || r_state == S_COMMIT) begin
            r_div <= 8'd0;
         end else if (w_last) begin
            r_div <= 8'd0;
         end else begin
            r_div <= r_div + 8'd1;
         end

         if (w_entering && w_next == S_LATCH) begin
            r_half <= 1'b0;
            r_bit  <= 3'd0;
         end else begin
            if (r_state == S_LATCH && w_last) begin
               r_half <= 1'b1;
            end
            if (r_state == S_BIT_HI && w_next == S_BIT_LO) begin
               r_bit <= r_bit + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sh1 <= 8'd0;
         r_sh2 <= 8'd0;
      end else if (w_sample) begin
         r_sh1 <= {~pad.pad_data1, r_sh1[7:1]};
         r_sh2 <= {~pad.pad_data2, r_sh2[7:1]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sw1     <= 8'd0;
         r_sw2     <= 8'd0;
         r_present <= 2'b00;
      end else if (w_commit) begin
         r_sw1     <= pad_valid(r_sh1) ? map_pad(r_sh1) : 8'h00;
         r_sw2     <= pad_valid(r_sh2) ? map_pad(r_sh2) : 8'h00;
         r_present <= {pad_valid(r_sh2), pad_valid(r_sh1)};
      end
   end

   // Strobes decode straight from the state register so reset drops them at once.
   assign pad.pad_latch = w_latch;
   assign pad.pad_clk   = w_pclk;
   assign switches_p1   = r_sw1;
   assign switches_p2   = r_sw2;
   assign present       = r_present;
   assign busy          = w_busy;
   assign done          = w_done;

endmodule

// File: tb/tb_gamepad_serial_reader.sv
// Bench for gamepad_serial_reader: two instances (D=1 and D=2) share clock, reset and vsync,
// each wired to its own behavioural pad pair replaying the same raw button streams.
module tb_gamepad_serial_reader;

   logic clk = 1'b0;
   logic reset;
   logic vsync;
   logic [7:0] raw1;
   logic [7:0] raw2;

   gamepad_serial_reader_if pif_a ();
   gamepad_serial_reader_if pif_b ();

   logic [7:0] sw1_a, sw2_a, sw1_b, sw2_b;
   logic [1:0] pres_a, pres_b;
   logic       busy_a, busy_b, done_a, done_b;

   gamepad_serial_reader #(.CLK_DIV(1)) dut_a (
      .clk(clk), .reset(reset), .vsync(vsync), .pad(pif_a),
      .switches_p1(sw1_a), .switches_p2(sw2_a), .present(pres_a),
      .busy(busy_a), .done(done_a)
   );

   gamepad_serial_reader #(.CLK_DIV(2)) dut_b (
      .clk(clk), .reset(reset), .vsync(vsync), .pad(pif_b),
      .switches_p1(sw1_b), .switches_p2(sw2_b), .present(pres_b),
      .busy(busy_b), .done(done_b)
   );

   always #5 clk = ~clk;

   // Behavioural pads: latch rewinds to the first button, each pad_clk rise advances one.
   logic [3:0] idx_a = 4'd8;
   logic [3:0] idx_b = 4'd8;
   logic       pclk_q_a = 1'b0;
   logic       pclk_q_b = 1'b0;

   always @(posedge clk) begin
      if (pif_a.pad_latch) idx_a <= 4'd0;
      else if (pif_a.pad_clk && !pclk_q_a && idx_a < 4'd8) idx_a <= idx_a + 4'd1;
      pclk_q_a <= pif_a.pad_clk;
      if (pif_b.pad_latch) idx_b <= 4'd0;
      else if (pif_b.pad_clk && !pclk_q_b && idx_b < 4'd8) idx_b <= idx_b + 4'd1;
      pclk_q_b <= pif_b.pad_clk;
   end

   assign pif_a.pad_data1 = (idx_a < 4'd8) ? raw1[idx_a[2:0]] : 1'b1;
   assign pif_a.pad_data2 = (idx_a < 4'd8) ? raw2[idx_a[2:0]] : 1'b1;
   assign pif_b.pad_data1 = (idx_b < 4'd8) ? raw1[idx_b[2:0]] : 1'b1;
   assign pif_b.pad_data2 = (idx_b < 4'd8) ? raw2[idx_b[2:0]] : 1'b1;

   logic [1:0]      dn, lt, pc, bz;
   logic [1:0][7:0] s1v, s2v;
   logic [1:0][1:0] prv;
   assign dn  = {done_b, done_a};
   assign lt  = {pif_b.pad_latch, pif_a.pad_latch};
   assign pc  = {pif_b.pad_clk, pif_a.pad_clk};
   assign bz  = {busy_b, busy_a};
   assign s1v = {sw1_b, sw1_a};
   assign s2v = {sw2_b, sw2_a};
   assign prv = {pres_b, pres_a};

   int checks = 0;
   int errors = 0;
   int dv [2] = '{1, 2};
   int done_cnt [2];
   int done_k [2];
   int latch_cnt [2];
   int rise_cnt [2];
   logic        pre_busy_b;
   logic [3:0]  snap_ctl;
   logic [17:0] snap_out;
   int          busy_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: each pressed (raw 0) button lands at its console bit; all-zero line is invalid.
   function automatic logic [7:0] ref_word(input logic [7:0] raw);
      int pos [8];
      logic [7:0] w;
      pos = '{4, 5, 6, 7, 2, 3, 0, 1};
      w = 8'h00;
      if (raw == 8'h00) return 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (!raw[i]) w[pos[i][2:0]] = 1'b1;
      end
      return w;
   endfunction

   // Raise vsync and watch ncyc cycles; optionally re-pulse vsync or pulse reset at given offsets.
   task automatic gather(input int ncyc, input int vs_at, input int rst_at);
      logic [1:0] pc_prev;
      for (int j = 0; j < 2; j++) begin
         done_cnt[j] = 0; done_k[j] = -1; latch_cnt[j] = 0; rise_cnt[j] = 0;
      end
      @(negedge clk);
      pc_prev = pc;
      vsync = 1'b1;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         for (int j = 0; j < 2; j++) begin
            if (dn[j]) begin
               done_cnt[j]++;
               if (done_k[j] < 0) done_k[j] = k;
            end
            if (lt[j]) latch_cnt[j]++;
            if (pc[j] && !pc_prev[j]) rise_cnt[j]++;
         end
         pc_prev = pc;
         if (k == 2 || k == vs_at + 2) vsync = 1'b0;
         if (k == vs_at) vsync = 1'b1;
         if (k == rst_at) begin
            pre_busy_b = busy_b;
            reset = 1'b0;
            #1;
            snap_ctl = {pif_b.pad_latch, pif_b.pad_clk, busy_b, done_b};
            snap_out = {sw1_b, sw2_b, pres_b};
         end
         if (k == rst_at + 2) reset = 1'b1;
      end
   endtask

   task automatic check_poll(input string tag);
      for (int j = 0; j < 2; j++) begin
         chk($sformatf("%s_d%0d_done_cnt", tag, dv[j]), done_cnt[j], 1);
         chk($sformatf("%s_d%0d_done_cycle", tag, dv[j]), done_k[j], 18 * dv[j] + 1);
         chk($sformatf("%s_d%0d_latch_cycles", tag, dv[j]), latch_cnt[j], 2 * dv[j]);
         chk($sformatf("%s_d%0d_clk_pulses", tag, dv[j]), rise_cnt[j], 8);
         chk($sformatf("%s_d%0d_sw1", tag, dv[j]), {24'd0, s1v[j]}, {24'd0, ref_word(raw1)});
         chk($sformatf("%s_d%0d_sw2", tag, dv[j]), {24'd0, s2v[j]}, {24'd0, ref_word(raw2)});
         chk($sformatf("%s_d%0d_present", tag, dv[j]), {30'd0, prv[j]},
             {30'd0, (raw2 != 8'h00), (raw1 != 8'h00)});
         chk($sformatf("%s_d%0d_busy_after", tag, dv[j]), {31'd0, bz[j]}, 32'd0);
      end
   endtask

   initial begin
      reset = 1'b0;
      vsync = 1'b1;
      raw1  = 8'hFF;
      raw2  = 8'hFF;
      repeat (3) @(negedge clk);
      chk("reset_ctl", {24'd0, lt, pc, bz, dn}, 32'd0);
      chk("reset_sw1", {16'd0, s1v}, 32'd0);
      chk("reset_sw2", {16'd0, s2v}, 32'd0);
      chk("reset_present", {28'd0, prv}, 32'd0);

      // vsync held high through reset release must not start a poll
      reset = 1'b1;
      busy_seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bz != 2'b00 || dn != 2'b00) busy_seen++;
      end
      chk("vsync_high_no_poll", busy_seen, 0);
      vsync = 1'b0;
      repeat (3) @(negedge clk);

      raw1 = 8'hFE; raw2 = 8'hFF;
      gather(60, -1, -1);
      check_poll("a_pressed");
      chk("a_pressed_literal", {16'd0, sw1_b, sw2_b}, {16'd0, 8'h10, 8'h00});

      raw1 = 8'h6F; raw2 = 8'hF7;
      gather(60, -1, -1);
      check_poll("up_right_start");
      chk("up_right_start_literal", {16'd0, sw1_a, sw2_a}, {16'd0, 8'h06, 8'h80});

      raw1 = 8'($urandom); raw2 = 8'h00;
      gather(60, -1, -1);
      check_poll("pad2_shorted");
      chk("pad2_shorted_present", {30'd0, pres_b}, 32'd1);

      raw1 = 8'($urandom); raw2 = 8'($urandom);
      gather(60, 10, -1);
      check_poll("vsync_while_busy");

      raw1 = 8'($urandom); raw2 = 8'($urandom);
      gather(60, -1, -1);
      check_poll("later_edge");

      raw1 = 8'hFE; raw2 = 8'h7F;
      gather(60, -1, 20);
      chk("midreset_was_busy", {31'd0, pre_busy_b}, 32'd1);
      chk("midreset_ctl", {28'd0, snap_ctl}, 32'd0);
      chk("midreset_outputs", {14'd0, snap_out}, 32'd0);
      chk("midreset_d2_no_done", done_cnt[1], 0);
      chk("midreset_d1_done_before", done_cnt[0], 1);
      chk("midreset_sw_after", {s1v, s2v}, 32'd0);
      chk("midreset_present_after", {28'd0, prv}, 32'd0);

      for (int n = 0; n < 8; n++) begin
         raw1 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         raw2 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         gather(60, -1, -1);
         check_poll($sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gamepad_serial_reader.md
Name: gamepad_serial_reader

Overview:
- Polls two NES-style serial gamepads (latch / clock / data shift-register protocol) once per frame.
- Converts the results into the active-high 8-bit switches_p1 / switches_p2 words consumed by the console top level.
- Sits directly upstream of the console's switches inputs, which the CPU reads at $FFFE.
- Is triggered by the console's own vsync, so the button state is stable for a whole frame.

Parameters:
CLK_DIV, 24, half-period of pad_clk in clk cycles (D); legal 1..255; 24 gives ~100 kHz at 4.857 MHz

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
vsync  in  1  frame sync from hvsync generator, same clock domain; rising edge starts a poll
pad_latch  out  1  latch strobe to both pads (active high)
pad_clk  out  1  shift clock to both pads (idle low)
pad_data1  in  1  serial data, pad 1, active-low buttons, pulled high when unplugged
pad_data2  in  1  serial data, pad 2, same as pad_data1
switches_p1  out  8  pad 1 buttons, active high: [0]Left [1]Right [2]Up [3]Down [4]A [5]B [6]Select [7]Start
switches_p2  out  8  pad 2 buttons, same mapping as switches_p1
present  out  2  [0] pad 1 frame valid, [1] pad 2 frame valid
busy  out  1  high while a poll is in progress
done  out  1  one-cycle strobe when switches/present update

Behaviour:
- Reset values (async, active-low): FSM=IDLE, pad_latch=0, pad_clk=0, switches_p1=switches_p2=0, present=2'b00, busy=0, done=0, shift registers=0, divider=0, vsync_q=1.
- vsync_q resets to 1 so that vsync held high through reset does not start a poll; a genuine rising edge is required.
- Edge detect: start = vsync & ~vsync_q (vsync_q is the registered vsync). Starts are honoured only in IDLE; edges while busy are ignored, not queued.
- FSM states: IDLE -> LATCH -> BIT_LO -> BIT_HI -> (BIT_LO for next bit | COMMIT) -> IDLE.
- The cycle in which start is seen is cycle N.
- LATCH state:
  - occupies cycles N+1 .. N+2D;
  - pad_latch=1, pad_clk=0, busy=1.
- Bit i (i = 0..7; bit order A, B, Select, Start, Up, Down, Left, Right):
  - BIT_LO lasts D cycles with pad_clk=0;
  - on its last cycle, pad_data1 and pad_data2 are sampled into shift registers, inverted to active high;
  - BIT_HI follows for D cycles with pad_clk=1;
  - the pad_clk rising edge advances the pad to the next bit.
- Eight full clock pulses are always issued; bit 7's BIT_HI ends at cycle N+18D.
- COMMIT state:
  - the FSM enters COMMIT on the edge ending cycle N+18D, and switches_p1, switches_p2 and present update on that same edge;
  - during COMMIT (cycle N+18D+1), done=1 and busy=1;
  - the FSM returns to IDLE next, where busy=0.
- Divider: 8-bit counter counting 0..D-1, cleared on every state entry. D=1 must work (single-cycle halves).
- Mapping from inverted sample s[i] (i = shift order) to output bits: out[4]=s0, out[5]=s1, out[6]=s2, out[7]=s3, out[2]=s4, out[3]=s5, out[0]=s6, out[1]=s7.
- Validity, evaluated per pad:
  - a pad whose 8 raw samples are all 0 (line shorted or pulled low) is invalid;
  - an invalid pad gets present bit 0 and its switches word forced to 8'h00;
  - otherwise present bit 1 and the mapped word is committed;
  - an unplugged pad (all raw 1s) is valid with switches word 8'h00.
- Outputs hold their last committed value between polls. There are no partial updates mid-poll.
- Reset asserted mid-poll:
  - immediately forces all reset values, with pad_latch and pad_clk dropping the same instant;
  - after deassert, the FSM waits for the next vsync rising edge.
- Simultaneous events:
  - a vsync edge in the COMMIT cycle is ignored;
  - a vsync edge in the first IDLE cycle after COMMIT starts a new poll.

Test Plan:
- D=2, pad1 drives raw serial 0,1,1,1,1,1,1,1 (A pressed), pad2 all 1s; pulse vsync -> pad_latch high for 4 cycles; 8 pad_clk pulses each 2 low / 2 high; done at N+37; switches_p1=8'h10, switches_p2=8'h00, present=2'b11.
- D=2, pad1 raw 1,1,1,1,0,1,1,0 (Up+Right), pad2 raw 1,1,1,0,1,1,1,1 (Start) -> switches_p1=8'h06, switches_p2=8'h80.
- D=2, pad2 held at 0 throughout -> present=2'b01, switches_p2=8'h00, pad1 decoded normally.
- Second vsync rising edge injected at N+10 during a poll -> no restart; exactly one done at N+37; next poll only on a later edge.
- Assert reset at N+20 mid-poll -> pad_latch=0, pad_clk=0, busy=0, switches=0, present=0 combinationally; no done until a fresh vsync edge after release.
- D=1, vsync held high across reset release -> no poll until vsync falls and rises again; then done at N+19.
